// File: rtl/sar_adc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sar_adc_ctrl
// Description : Successive-approximation controller for a capacitor DAC and
//               comparator. Runs a start/busy/done conversion handshake.
//               Optional macro OVERSAMPLE_EN runs 4 conversions per start and
//               returns their truncated average.
// Revision    : 1.0 - initial release
// ============================================================================
module sar_adc_ctrl #(
    parameter int WIDTH      = 8,
    parameter int SAMPLE_CYC = 8,
    parameter int SETTLE_CYC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             cmp_in,
    output logic             sample,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int c_CNT_MAX = (SAMPLE_CYC > SETTLE_CYC) ? SAMPLE_CYC : SETTLE_CYC;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_BIT_W   = $clog2(WIDTH);

    localparam logic [c_CNT_W-1:0] c_SAMPLE_LAST = c_CNT_W'(SAMPLE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SETTLE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);
    localparam logic [c_BIT_W-1:0] c_BIT_MSB     = c_BIT_W'(WIDTH - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_ONE     = c_BIT_W'(1);
    localparam logic [WIDTH-1:0]   c_MSB_CODE    = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SAMPLE = 3'd1,
        S_SETTLE = 3'd2,
        S_DECIDE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [c_BIT_W-1:0]   r_bit;
    logic [c_BIT_W-1:0]   w_bit_nxt;
    logic [WIDTH-1:0]     r_code;
    logic [WIDTH-1:0]     w_code_nxt;
    logic [WIDTH-1:0]     w_trial;
    logic [WIDTH-1:0]     r_result;
    logic [WIDTH-1:0]     w_result_nxt;
    logic                 r_cmp_meta;
    logic                 r_cmp_s;
    logic                 r_sample;
    logic                 r_busy;
    logic                 r_done;

`ifdef OVERSAMPLE_EN
    logic [WIDTH+1:0]     r_acc;
    logic [WIDTH+1:0]     w_acc_nxt;
    logic [WIDTH+1:0]     w_sum;
    logic [1:0]           r_pass;
    logic [1:0]           w_pass_nxt;
`endif

    // Comparator output is asynchronous to clk; settle time covers this latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmp_meta <= 1'b0;
            r_cmp_s    <= 1'b0;
        end else begin
            r_cmp_meta <= cmp_in;
            r_cmp_s    <= r_cmp_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_code   <= '0;
            r_result <= '0;
            r_sample <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_bit    <= w_bit_nxt;
            r_code   <= w_code_nxt;
            r_result <= w_result_nxt;
            r_sample <= (w_state_nxt == S_SAMPLE);
            r_busy   <= (w_state_nxt != S_IDLE);
            r_done   <= (w_state_nxt == S_DONE);
        end
    end

`ifdef OVERSAMPLE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_pass <= '0;
        end else begin
            r_acc  <= w_acc_nxt;
            r_pass <= w_pass_nxt;
        end
    end
`endif

    // Decision for the current bit plus the trial of the next lower bit.
    always_comb begin
        w_trial = r_code;
        if (!r_cmp_s) begin
            w_trial[r_bit] = 1'b0;
        end
        if (r_bit != '0) begin
            w_trial[r_bit - c_BIT_ONE] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_bit_nxt    = r_bit;
        w_code_nxt   = r_code;
        w_result_nxt = r_result;
`ifdef OVERSAMPLE_EN
        w_acc_nxt    = r_acc;
        w_pass_nxt   = r_pass;
        w_sum        = r_acc + {2'b00, w_trial};
`endif
        if (r_state == S_IDLE) begin
            if (start && ena) begin
                w_state_nxt = S_SAMPLE;
                w_cnt_nxt   = '0;
                w_code_nxt  = '0;
`ifdef OVERSAMPLE_EN
                w_acc_nxt   = '0;
                w_pass_nxt  = '0;
`endif
            end
        end else if (!ena) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_code_nxt  = '0;
`ifdef OVERSAMPLE_EN
            w_acc_nxt   = '0;
            w_pass_nxt  = '0;
`endif
        end else begin
            case (r_state)
                S_SAMPLE: begin
                    if (r_cnt == c_SAMPLE_LAST) begin
                        w_state_nxt = S_SETTLE;
                        w_cnt_nxt   = '0;
                        w_bit_nxt   = c_BIT_MSB;
                        w_code_nxt  = c_MSB_CODE;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == c_SETTLE_LAST) begin
                        w_state_nxt = S_DECIDE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
                S_DECIDE: begin
                    w_code_nxt = w_trial;
                    if (r_bit != '0) begin
                        w_bit_nxt   = r_bit - c_BIT_ONE;
                        w_state_nxt = S_SETTLE;
                    end else begin
`ifdef OVERSAMPLE_EN
                        if (r_pass != 2'd3) begin
                            w_acc_nxt   = w_sum;
                            w_pass_nxt  = r_pass + 2'd1;
                            w_code_nxt  = '0;
                            w_state_nxt = S_SAMPLE;
                        end else begin
                            w_acc_nxt    = w_sum;
                            w_result_nxt = w_sum[WIDTH+1:2];
                            w_state_nxt  = S_DONE;
                        end
`else
                        // Result is loaded here so it is already valid in the done cycle.
                        w_result_nxt = w_trial;
                        w_state_nxt  = S_DONE;
`endif
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign sample   = r_sample;
    assign dac_code = r_code;
    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = r_result;

endmodule
`default_nettype wire

// File: tb/tb_sar_adc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sar_adc_ctrl
// Description : Directed self-checking bench for sar_adc_ctrl with a
//               behavioural comparator model (cmp_in = Vin >= dac_code).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sar_adc_ctrl;

    localparam int W = 8;
`ifdef OVERSAMPLE_EN
    localparam int LAT = 193;
`else
    localparam int LAT = 49;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ena = 1'b0;
    logic         start = 1'b0;
    logic         cmp_in;
    logic         sample;
    logic [W-1:0] dac_code;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    logic [7:0]   vin = 8'h00;
    logic         tie_hi = 1'b0;
    logic         tie_lo = 1'b0;
    logic         hold_start = 1'b0;
    logic         use_tab = 1'b0;
    logic [7:0]   vin_tab [0:3];
    logic [7:0]   exp_trial [0:7];

    logic         sample_log [0:511];
    logic         busy_log   [0:511];
    logic         done_log   [0:511];
    logic [W-1:0] code_log   [0:511];

    int checks = 0;
    int errors = 0;
    int done_at;
    int n_done;
    int busy_pre;

    sar_adc_ctrl #(.WIDTH(W), .SAMPLE_CYC(8), .SETTLE_CYC(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .start    (start),
        .cmp_in   (cmp_in),
        .sample   (sample),
        .dac_code (dac_code),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    assign cmp_in = tie_hi ? 1'b1 : (tie_lo ? 1'b0 : (vin >= dac_code));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 600 && busy; i++) next_cycle();
        chk("idle_wait", {31'd0, busy}, 32'd0);
        next_cycle();
    endtask

    // Starts a conversion from IDLE and logs outputs for cycles 1..ncyc after capture.
    task automatic convert(input int ncyc, input int restart_at, input int ena_drop);
        int k;
        k        = 0;
        done_at  = -1;
        n_done   = 0;
        busy_pre = 0;
        start = 1'b1;
        next_cycle();
        start = hold_start;
        for (int c = 1; c <= ncyc; c++) begin
            if (use_tab && sample && (c == 1 || !sample_log[c-1]) && k < 4) begin
                vin = vin_tab[k];
                k++;
            end
            sample_log[c] = sample;
            busy_log[c]   = busy;
            done_log[c]   = done;
            code_log[c]   = dac_code;
            if (done) begin
                n_done++;
                if (done_at < 0) done_at = c;
            end else if (busy && done_at < 0) begin
                busy_pre++;
            end
            if (c == restart_at) start = 1'b1;
            else if (c == restart_at + 1) start = hold_start;
            if (c == ena_drop) ena = 1'b0;
            next_cycle();
        end
        start = 1'b0;
        ena   = 1'b1;
    endtask

    initial begin
        vin_tab[0] = 8'h40; vin_tab[1] = 8'h41; vin_tab[2] = 8'h41; vin_tab[3] = 8'h42;
        exp_trial[0] = 8'h80; exp_trial[1] = 8'hC0; exp_trial[2] = 8'hA0; exp_trial[3] = 8'hB0;
        exp_trial[4] = 8'hA8; exp_trial[5] = 8'hA4; exp_trial[6] = 8'hA6; exp_trial[7] = 8'hA5;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_sample", {31'd0, sample}, 32'd0);
        chk("rst_dac", {24'd0, dac_code}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", {24'd0, result}, 32'd0);
        rst_n = 1'b1;
        ena   = 1'b1;
        next_cycle();

        // 1: Vin = 0xA5
        vin = 8'hA5;
        convert(LAT + 3, -1, -1);
        for (int b = 0; b < 8; b++) chk($sformatf("trial%0d", b), {24'd0, code_log[10 + 5*b]}, {24'd0, exp_trial[b]});
        chk("t1_sample_c1", {31'd0, sample_log[1]}, 32'd1);
        chk("t1_dac_c1", {24'd0, code_log[1]}, 32'd0);
        chk("t1_sample_c9", {31'd0, sample_log[9]}, 32'd0);
        chk("t1_done_at", done_at, LAT);
        chk("t1_n_done", n_done, 1);
        chk("t1_busy_pre", busy_pre, LAT - 1);
        chk("t1_busy_done", {31'd0, busy_log[LAT]}, 32'd1);
        chk("t1_busy_after", {31'd0, busy_log[LAT + 1]}, 32'd0);
        chk("t1_result", {24'd0, result}, 32'hA5);
        wait_idle();

        // 2: comparator tied high / low
        tie_hi = 1'b1;
        convert(LAT + 3, -1, -1);
        chk("t2_hi_result", {24'd0, result}, 32'hFF);
        chk("t2_hi_done_at", done_at, LAT);
        wait_idle();
        tie_hi = 1'b0;
        tie_lo = 1'b1;
        convert(LAT + 3, -1, -1);
        chk("t2_lo_result", {24'd0, result}, 32'h00);
        chk("t2_lo_done_at", done_at, LAT);
        wait_idle();
        tie_lo = 1'b0;

        // 3: start re-pulsed while busy, then held high
        vin = 8'h5A;
        convert(2*LAT + 5, 10, -1);
        chk("t3_repulse_n_done", n_done, 1);
        chk("t3_repulse_done_at", done_at, LAT);
        chk("t3_repulse_result", {24'd0, result}, 32'h5A);
        wait_idle();
        hold_start = 1'b1;
        convert(2*LAT + 5, -1, -1);
        hold_start = 1'b0;
        chk("t3_hold_first", {31'd0, done_log[LAT]}, 32'd1);
        chk("t3_hold_second", {31'd0, done_log[2*LAT + 1]}, 32'd1);
        chk("t3_hold_n_done", n_done, 2);
        wait_idle();

        // 4: abort by ena drop
        vin = 8'hA5;
        convert(LAT + 3, -1, -1);
        chk("t4_first_result", {24'd0, result}, 32'hA5);
        wait_idle();
        vin = 8'h3C;
        convert(30, -1, 20);
        chk("t4_busy_c20", {31'd0, busy_log[20]}, 32'd1);
        chk("t4_busy_c21", {31'd0, busy_log[21]}, 32'd0);
        chk("t4_dac_c21", {24'd0, code_log[21]}, 32'd0);
        chk("t4_n_done", n_done, 0);
        chk("t4_result", {24'd0, result}, 32'hA5);
        wait_idle();

        // 5: async reset mid-SETTLE
        vin = 8'hA5;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        repeat (9) next_cycle();
        chk("t5_pre_busy", {31'd0, busy}, 32'd1);
        chk("t5_pre_dac", {24'd0, dac_code}, 32'h80);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_sample", {31'd0, sample}, 32'd0);
        chk("t5_dac", {24'd0, dac_code}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_done", {31'd0, done}, 32'd0);
        chk("t5_result", {24'd0, result}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        vin = 8'h3C;
        convert(LAT + 3, -1, -1);
        chk("t5_post_result", {24'd0, result}, 32'h3C);
        chk("t5_post_done_at", done_at, LAT);
        wait_idle();

`ifdef OVERSAMPLE_EN
        // 6: per-conversion Vin 40,41,41,42 averaged
        use_tab = 1'b1;
        convert(LAT + 3, -1, -1);
        use_tab = 1'b0;
        chk("t6_done_at", done_at, LAT);
        chk("t6_n_done", n_done, 1);
        chk("t6_result", {24'd0, result}, 32'h41);
        wait_idle();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
